// File: rtl/draw_queue.sv
// Draw-command queue: buffers changed grid cells from the scanner and presents
// them to the display writer as filled pixel rectangles over a valid/ready handshake.
module draw_queue #(
  parameter int DEPTH   = 8,
  parameter int CELL_PX = 20
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        diff,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [2:0]  obj_code,
  input  logic        flush,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [8:0]  cmd_x0,
  output logic [8:0]  cmd_x1,
  output logic [7:0]  cmd_y0,
  output logic [7:0]  cmd_y1,
  output logic [15:0] cmd_color,
  output logic [3:0]  fifo_count,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, PRESENT} state_t;

  function automatic logic [9:0] cell_edge(input logic [3:0] c);
    return 10'(c) * 10'(CELL_PX);
  endfunction

  function automatic logic [15:0] obj_color(input logic [2:0] code);
    case (code)
      3'b001:  return 16'h07E0;
      3'b010:  return 16'h03E0;
      3'b011:  return 16'hF800;
      3'b100:  return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  state_t          state_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [10:0]     mem_q [DEPTH];
  logic [10:0]     head;
  logic            push_req, push_ok, pop, full, nonempty;
  logic [8:0]      x0_q, x1_q;
  logic [7:0]      y0_q, y1_q;
  logic [15:0]     color_q;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    push_req = enable & diff & (y <= 4'd11) & ~flush;
    full     = (count_q == CW'(DEPTH));
    nonempty = (count_q != '0);
    // Output register reloads whenever it is empty or being handed off
    pop      = ~flush & nonempty & ((state_q == IDLE) | cmd_ready);
    push_ok  = push_req & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      ovf_d   = ovf_q | (push_req & ~push_ok);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {x, y, obj_code};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (pop) state_q <= PRESENT;
        PRESENT: if (!pop && cmd_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (pop) begin
        x0_q    <= 9'(cell_edge(head[10:7]));
        x1_q    <= 9'(cell_edge(head[10:7]) + 10'(CELL_PX - 1));
        y0_q    <= 8'(cell_edge(head[6:3]));
        y1_q    <= 8'(cell_edge(head[6:3]) + 10'(CELL_PX - 1));
        color_q <= obj_color(head[2:0]);
      end
    end
  end

  assign cmd_valid  = (state_q == PRESENT);
  assign cmd_x0     = x0_q;
  assign cmd_x1     = x1_q;
  assign cmd_y0     = y0_q;
  assign cmd_y1     = y1_q;
  assign cmd_color  = color_q;
  assign fifo_count = 4'(count_q);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_draw_queue.sv
// Bench for draw_queue: directed scenarios plus random traffic, scored against
// a queue-based model of accepted cells and the expected rectangles.
module tb_draw_queue;

  localparam int DEPTH = 8;

  logic        clk, nrst, enable, diff, flush, cmd_ready;
  logic [3:0]  x, y;
  logic [2:0]  obj_code;
  logic        cmd_valid, overflow;
  logic [8:0]  cmd_x0, cmd_x1;
  logic [7:0]  cmd_y0, cmd_y1;
  logic [15:0] cmd_color;
  logic [3:0]  fifo_count;

  draw_queue #(.DEPTH(DEPTH), .CELL_PX(20)) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .diff(diff), .x(x), .y(y),
    .obj_code(obj_code), .flush(flush), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1),
    .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  typedef struct {int x0; int x1; int y0; int y1; int col;} cmd_t;

  cmd_t exp_q[$];
  int   m_cnt = 0;
  bit   m_slot = 0;
  bit   m_ovf = 0;
  bit   mon_en = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int cx, input int cy, input int o);
    cmd_t c;
    c.x0 = cx * 20;
    c.x1 = c.x0 + 19;
    c.y0 = cy * 20;
    c.y1 = c.y0 + 19;
    case (o)
      1: c.col = 'h07E0;
      2: c.col = 'h03E0;
      3: c.col = 'hF800;
      4: c.col = 'hFFFF;
      default: c.col = 0;
    endcase
    return c;
  endfunction

  // Model of one clock edge using the inputs held across it
  task automatic model_edge();
    bit pr, pop;
    int keep;
    if (!nrst) return;
    pr  = enable && diff && (y <= 11) && !flush;
    pop = !flush && (m_cnt > 0) && (!m_slot || cmd_ready);
    if (flush) begin
      keep = (m_slot && !cmd_ready) ? 1 : 0;
      while (exp_q.size() > keep) void'(exp_q.pop_back());
      m_cnt  = 0;
      m_ovf  = 0;
      m_slot = m_slot && !cmd_ready;
    end else begin
      if (pop) begin
        m_cnt--;
        m_slot = 1;
      end else if (m_slot && cmd_ready) begin
        m_slot = 0;
      end
      if (pr) begin
        if (m_cnt < DEPTH) begin
          m_cnt++;
          exp_q.push_back(mk(int'(x), int'(y), int'(obj_code)));
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic step(input logic e, input logic d, input logic [3:0] xx,
                      input logic [3:0] yy, input logic [2:0] o,
                      input logic f, input logic r);
    enable = e; diff = d; x = xx; y = yy; obj_code = o; flush = f; cmd_ready = r;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, r);
  endtask

  task automatic rand_push(input logic r);
    step(1, 1, 4'($urandom_range(15, 0)), 4'($urandom_range(11, 0)),
         3'($urandom_range(7, 0)), 0, r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_x0"}, cmd_x0, 0);
    chk({tag, "_x1"}, cmd_x1, 0);
    chk({tag, "_y0"}, cmd_y0, 0);
    chk({tag, "_y1"}, cmd_y1, 0);
    chk({tag, "_color"}, cmd_color, 0);
  endtask

  // Monitor: mid-cycle comparison of status and the presented command
  initial begin
    cmd_t e;
    forever begin
      @(negedge clk);
      if (mon_en && nrst) begin
        chk("fifo_count", fifo_count, m_cnt);
        chk("overflow", overflow, m_ovf);
        chk("cmd_valid", cmd_valid, m_slot);
        if (m_slot && exp_q.size() > 0) begin
          e = exp_q[0];
          chk("cmd_x0", cmd_x0, e.x0);
          chk("cmd_x1", cmd_x1, e.x1);
          chk("cmd_y0", cmd_y0, e.y0);
          chk("cmd_y1", cmd_y1, e.y1);
          chk("cmd_color", cmd_color, e.col);
          if (cmd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rpct;
    nrst = 1; enable = 0; diff = 0; x = 0; y = 0; obj_code = 0; flush = 0; cmd_ready = 0;
    #1 nrst = 0;
    #1 chk_zero("reset");
    @(posedge clk); @(posedge clk);
    #2 nrst = 1;
    mon_en = 1;

    // Single cell
    step(1, 1, 3, 2, 3'b011, 0, 1);
    chk("single_wait_valid", cmd_valid, 0);
    idle(1, 1);
    chk("single_valid", cmd_valid, 1);
    chk("single_x0", cmd_x0, 60);
    chk("single_x1", cmd_x1, 79);
    chk("single_y0", cmd_y0, 40);
    chk("single_y1", cmd_y1, 59);
    chk("single_color", cmd_color, 'hF800);
    idle(1, 1);
    chk("single_idle", cmd_valid, 0);

    // Backpressure then burst drain
    for (int i = 0; i < 3; i++) rand_push(0);
    idle(2, 0);
    chk("bp_count", fifo_count, 2);
    idle(5, 1);

    // Overflow and flush
    for (int i = 0; i < 10; i++) rand_push(0);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    step(1, 1, 7, 7, 3'b001, 1, 0);
    chk("flush_count", fifo_count, 0);
    chk("flush_ovf", overflow, 0);
    chk("flush_keep_valid", cmd_valid, 1);
    idle(3, 1);

    // Full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 9; i++) rand_push(0);
    chk("full_count", fifo_count, 8);
    for (int i = 0; i < 12; i++) rand_push(1);
    chk("pushpop_count", fifo_count, 8);
    chk("pushpop_ovf", overflow, 0);
    idle(10, 1);

    // Boundary cell and out-of-range row
    step(1, 1, 15, 11, 3'b100, 0, 1);
    idle(1, 1);
    chk("bound_x0", cmd_x0, 300);
    chk("bound_x1", cmd_x1, 319);
    chk("bound_y0", cmd_y0, 220);
    chk("bound_y1", cmd_y1, 239);
    chk("bound_color", cmd_color, 'hFFFF);
    step(1, 1, 5, 12, 3'b001, 0, 1);
    idle(1, 1);
    chk("row12_count", fifo_count, 0);
    chk("row12_valid", cmd_valid, 0);

    // Random traffic
    rpct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rpct = $urandom_range(100, 0);
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 8,
           4'($urandom_range(15, 0)), 4'($urandom_range(13, 0)),
           3'($urandom_range(7, 0)), $urandom_range(63, 0) == 0,
           $urandom_range(99, 0) < rpct);
    end
    idle(12, 1);
    chk("drain", exp_q.size(), 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) rand_push(0);
    chk("pre_rst_count", fifo_count, 5);
    chk("pre_rst_valid", cmd_valid, 1);
    #1 nrst = 0;
    #1 chk_zero("async_rst");
    exp_q.delete();
    m_cnt = 0; m_slot = 0; m_ovf = 0;
    idle(2, 1);
    nrst = 1;
    idle(3, 0);
    chk("post_rst_valid", cmd_valid, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
